arm_fetch: RTL and testbench

ARM_FETCH -- requirements
Module: arm_fetch

---
 rtl/arm_defs_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/arm_fetch.sv | 134 +++++++++++++
 tb/tb_arm_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_defs (package)
// Description : Shared core definitions: decode constants, fetch FSM state
//               encoding, prefetch depth and machine word size.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_defs;

    // Decode constants
    localparam logic [3:0] c_COND_AL = 4'hE;   // "always" condition code
    localparam logic [3:0] c_REG_PC  = 4'd15;  // r15 is the program counter

    // Machine word size in bytes; sequential fetch advances by this much
    localparam int unsigned c_WORD_BYTES = 4;

    // Prefetch buffer geometry
    localparam int unsigned c_FETCH_DEPTH   = 2;
    localparam int unsigned c_FETCH_ENTRY_W = 64;   // {pc, inst}

    // Fetch FSM state encoding
    localparam logic [1:0] c_FETCH_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH_REQ   = 2'd1;
    localparam logic [1:0] c_FETCH_FLUSH = 2'd2;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch FIFO of {pc, inst} entries with push, pop and
//               a single-cycle flush. Head entry is always visible.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               push, push_data - write an entry (ignored when full)
//               pop             - retire the head entry (ignored when empty)
//               flush           - drop all entries; wins over push and pop
//               count           - number of stored entries
//               head            - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import arm_defs::*;
#(
    parameter  int unsigned DEPTH = c_FETCH_DEPTH,
    parameter  int unsigned WIDTH = c_FETCH_ENTRY_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full buffer still accepts a push when the head leaves the same cycle.
    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/arm_fetch.sv
`default_nettype none
// ============================================================================
// Module      : arm_fetch
// Description : Instruction fetch unit. Issues one word read at a time into
//               a small prefetch buffer and presents the head to the decoder.
//               A redirect flushes the buffer and restarts at the target; an
//               in-flight read is allowed to finish and its data is dropped.
// Ports       : clk, rst                 - clock, async active-high reset
//               mem_req/addr/ack/rdata   - instruction memory read port
//               inst/inst_pc/inst_valid  - head instruction to decoder
//               inst_ready               - decoder consumes head this cycle
//               redirect/redirect_pc     - taken branch and its target
// Revision    : 1.0 - initial release
// ============================================================================
module arm_fetch
    import arm_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = c_FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_addr;   // address of the read in flight

    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [CNT_W-1:0] w_count;
    logic [63:0]      w_head;
    logic             w_has_room;

    assign w_has_room = (w_count < CNT_W'(DEPTH));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_FETCH_IDLE: begin
                if (!redirect && w_has_room) begin
                    w_state_next = c_FETCH_REQ;
                end
            end
            c_FETCH_REQ: begin
                // The bus cannot abort a read, so an un-acked redirect waits
                // out the old transfer in FLUSH.
                if (mem_ack) begin
                    w_state_next = c_FETCH_IDLE;
                end else if (redirect) begin
                    w_state_next = c_FETCH_FLUSH;
                end
            end
            c_FETCH_FLUSH: begin
                if (mem_ack) begin
                    w_state_next = c_FETCH_IDLE;
                end
            end
            default: w_state_next = c_FETCH_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_req  = (r_state == c_FETCH_REQ) || (r_state == c_FETCH_FLUSH);
        mem_addr = (r_state == c_FETCH_IDLE) ? r_fetch_pc : r_req_addr;
        w_push   = (r_state == c_FETCH_REQ) && mem_ack && !redirect;
        w_flush  = redirect;
        w_pop    = inst_valid && inst_ready && !redirect;
    end

    // ------------------------------------------------------ fetch addresses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                r_fetch_pc <= word_align(redirect_pc);
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'(c_WORD_BYTES);
            end
            // Freeze the issued address so a redirect cannot disturb it.
            if (r_state == c_FETCH_IDLE && w_state_next == c_FETCH_REQ) begin
                r_req_addr <= r_fetch_pc;
            end
        end
    end

    // ------------------------------------------------------ prefetch buffer
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_req_addr, mem_rdata}),
        .pop       (w_pop),
        .flush     (w_flush),
        .count     (w_count),
        .head      (w_head)
    );

    assign inst_valid = (w_count != '0);
    assign inst_pc    = w_head[63:32];
    assign inst       = w_head[31:0];

endmodule
`default_nettype wire

// File: tb/tb_arm_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_fetch
// Description : Directed self-checking bench for arm_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_fetch;

    localparam logic [31:0] c_JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    arm_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Instruction word returned for a given address
    function automatic logic [31:0] dat(input logic [31:0] pc);
        return pc ^ 32'hE000_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect an outstanding read at addr, acknowledge it for one cycle
    task automatic ack_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"}, 32'(mem_req), 32'd1);
        check({tag, "_addr"}, mem_addr, addr);
        mem_ack   = 1'b1;
        mem_rdata = dat(addr);
        step();
        mem_ack   = 1'b0;
        mem_rdata = c_JUNK;
    endtask

    task automatic check_inst(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_pc"}, inst_pc, pc);
        check({tag, "_inst"}, inst, dat(pc));
    endtask

    // Reset, release, and advance into the first REQ cycle
    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rel_idle_req", 32'(mem_req), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = c_JUNK;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();

        // Reset values
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);

        // Streaming: one instruction every two cycles
        rst = 1'b0;
        check("s1_idle", 32'(mem_req), 32'd0);
        inst_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            ack_req("s1", 32'(i * 4));
            check_inst("s1", 32'(i * 4));
            check("s1_gap_req", 32'(mem_req), 32'd0);
            step();
            check("s1_popped", 32'(inst_valid), 32'd0);
        end

        // Stalled decoder: two fetches fill the buffer, then order on drain
        do_reset();
        ack_req("s2a", 32'h0);
        step();
        ack_req("s2b", 32'h4);
        for (int i = 0; i < 3; i++) begin
            check("s2_full_noreq", 32'(mem_req), 32'd0);
            check("s2_head_pc", inst_pc, 32'h0);
            step();
        end
        check_inst("s2_head", 32'h0);
        inst_ready = 1'b1;
        step();
        check_inst("s2_second", 32'h4);
        check("s2_still_full_noreq", 32'(mem_req), 32'd0);
        step();
        check("s2_empty", 32'(inst_valid), 32'd0);
        check("s2_refetch_req", 32'(mem_req), 32'd1);
        check("s2_refetch_addr", mem_addr, 32'h8);

        // Redirect while a read is outstanding -> FLUSH, old data dropped
        do_reset();
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("s3_flush_req", 32'(mem_req), 32'd1);
            check("s3_flush_addr", mem_addr, 32'h0);
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack   = 1'b0;
        mem_rdata = c_JUNK;
        check("s3_dropped", 32'(inst_valid), 32'd0);
        check("s3_idle", 32'(mem_req), 32'd0);
        step();
        ack_req("s3_tgt", 32'h0000_0100);
        check_inst("s3_tgt", 32'h0000_0100);

        // Redirect coinciding with mem_ack, one entry buffered
        do_reset();
        ack_req("s4a", 32'h0);
        check_inst("s4_one", 32'h0);
        step();
        check("s4_req_addr", mem_addr, 32'h4);
        mem_ack     = 1'b1;
        mem_rdata   = dat(32'h4);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        mem_ack  = 1'b0;
        redirect = 1'b0;
        check("s4_flushed", 32'(inst_valid), 32'd0);
        check("s4_idle", 32'(mem_req), 32'd0);
        step();
        ack_req("s4_tgt", 32'h0000_0200);
        check_inst("s4_tgt", 32'h0000_0200);

        // Redirect from IDLE to the top of memory, then wrap to zero
        do_reset();
        inst_ready = 1'b1;
        ack_req("s5a", 32'h0);
        check_inst("s5a", 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        check("s5_flushed", 32'(inst_valid), 32'd0);
        check("s5_idle", 32'(mem_req), 32'd0);
        step();
        ack_req("s5_top", 32'hFFFF_FFFC);
        check_inst("s5_top", 32'hFFFF_FFFC);
        step();
        ack_req("s5_wrap", 32'h0);
        check_inst("s5_wrap", 32'h0);

        // Reset during an outstanding read, ack arriving inside reset
        do_reset();
        check("s6_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_async_req", 32'(mem_req), 32'd0);
        check("s6_async_addr", mem_addr, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = dat(32'h0);
        step();
        step();
        check("s6_rst_valid", 32'(inst_valid), 32'd0);
        check("s6_rst_inst", inst, 32'h0);
        check("s6_rst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        step();
        mem_ack   = 1'b0;
        mem_rdata = c_JUNK;
        check("s6_late_ack_ignored", 32'(inst_valid), 32'd0);
        ack_req("s6_new", 32'h0);
        check_inst("s6_new", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
